// File: rtl/fc_accumulator.sv
// Neuron output accumulator: sums sign-magnitude products, adds bias, rescales,
// applies optional ReLU and saturation, and hands the activation downstream.
//
// state | meaning
// ACCUM | accepting product beats into acc
// BIAS  | adding the aligned bias into acc
// NORM  | rescaling, clamping and registering the activation
// HOLD  | presenting out_data until the consumer takes it
module fc_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_product,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_overflow
);

  localparam int PW = 2*DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] MAG_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {ACCUM, BIAS, NORM, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [ACC_WIDTH-1:0]    acc, acc_nxt;
  logic [ACC_WIDTH-1:0]    prod_mag, prod_tc, bias_mag, bias_tc;
  logic [ACC_WIDTH-1:0]    acc_abs, acc_shr;
  logic [DATA_WIDTH-1:0]   bias_q, bias_nxt, data_nxt;
  logic                    valid_nxt, ovf_nxt, acc_neg;

  // Negative zero falls out naturally: negating a zero magnitude is zero.
  assign prod_mag = {{(ACC_WIDTH-PW+1){1'b0}}, in_product[PW-2:0]};
  assign prod_tc  = in_product[PW-1] ? -prod_mag : prod_mag;
  assign bias_mag = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, bias_q[DATA_WIDTH-2:0]};
  assign bias_tc  = (bias_q[DATA_WIDTH-1] ? -bias_mag : bias_mag) << FRAC_BITS;

  assign acc_neg = acc[ACC_WIDTH-1];
  assign acc_abs = acc_neg ? -acc : acc;
  assign acc_shr = acc_abs >> FRAC_BITS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      bias_q       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      bias_q       <= bias_nxt;
      out_valid    <= valid_nxt;
      out_data     <= data_nxt;
      out_overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    bias_nxt  = bias_q;
    case (state)
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = acc + prod_tc;
          if (in_last) begin
            bias_nxt  = bias;
            state_nxt = BIAS;
          end
        end
      end
      BIAS: begin
        acc_nxt   = acc + bias_tc;
        state_nxt = NORM;
      end
      NORM: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          acc_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    valid_nxt = out_valid;
    data_nxt  = out_data;
    ovf_nxt   = out_overflow;
    case (state)
      NORM: begin
        valid_nxt = 1'b1;
        if (acc_neg && RELU_EN) begin
          data_nxt = '0;
          ovf_nxt  = 1'b0;
        end else if (acc_shr > MAG_MAX) begin
          data_nxt = {acc_neg, {(DATA_WIDTH-1){1'b1}}};
          ovf_nxt  = 1'b1;
        end else begin
          // A magnitude that truncates to zero never carries a sign.
          data_nxt = {acc_neg && (acc_shr[DATA_WIDTH-2:0] != '0),
                      acc_shr[DATA_WIDTH-2:0]};
          ovf_nxt  = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc_accumulator.sv
// Bench for fc_accumulator: directed cases plus random vectors, run on a
// ReLU and a linear instance in lockstep and checked against an arithmetic model.
module tb_fc_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_product;
  logic [15:0] bias;
  logic        in_ready_r, in_ready_l, out_valid_r, out_valid_l;
  logic        out_overflow_r, out_overflow_l;
  logic [15:0] out_data_r, out_data_l;

  int errors = 0;
  int checks = 0;

  logic [31:0] vec[$];
  logic [15:0] vbias;
  logic [15:0] got_r, got_l;

  always #5 clk = ~clk;

  fc_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8), .RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_product(in_product), .in_last(in_last), .bias(bias),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_overflow(out_overflow_r));

  fc_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8), .RELU_EN(1'b0)) u_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_product(in_product), .in_last(in_last), .bias(bias),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .out_overflow(out_overflow_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, data} from exact integer arithmetic on the beats.
  function automatic logic [16:0] model(input logic [31:0] beats[$], input logic [15:0] b,
                                        input bit relu);
    longint sum, mag, a, m;
    bit     neg;
    sum = 0;
    foreach (beats[i]) begin
      mag = longint'(beats[i][30:0]);
      sum += beats[i][31] ? -mag : mag;
    end
    mag = longint'(b[14:0]) * 256;
    sum += b[15] ? -mag : mag;
    neg = (sum < 0);
    a   = neg ? -sum : sum;
    m   = a / 256;
    if (neg && relu) return 17'h0;
    if (m > 32767) return {1'b1, neg, 15'h7FFF};
    return {1'b0, neg && (m != 0), m[14:0]};
  endfunction

  task automatic run_vector(input int hold);
    logic [16:0] er, el;
    er = model(vec, vbias, 1'b1);
    el = model(vec, vbias, 1'b0);
    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      chk("beat_ready", {30'd0, in_ready_r, in_ready_l}, 32'd3);
      in_valid   = 1'b1;
      in_product = vec[i];
      in_last    = (i == vec.size() - 1);
      bias       = in_last ? vbias : 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; bias = 16'($urandom);
    chk("bias_cycle", {30'd0, out_valid_r, in_ready_r}, 32'd0);
    @(negedge clk);
    chk("norm_cycle", {30'd0, out_valid_r, in_ready_r}, 32'd0);
    @(negedge clk);
    chk("latency_valid", {30'd0, out_valid_r, out_valid_l}, 32'd3);
    chk("relu_out", {15'd0, out_overflow_r, out_data_r}, {15'd0, er});
    chk("lin_out", {15'd0, out_overflow_l, out_data_l}, {15'd0, el});
    got_r = out_data_r;
    got_l = out_data_l;
    for (int h = 0; h < hold; h++) begin
      in_valid   = 1'b1;
      in_product = $urandom;
      in_last    = 1'($urandom);
      bias       = 16'($urandom);
      @(negedge clk);
      chk("hold_relu", {13'd0, out_valid_r, in_ready_r, out_overflow_r, out_data_r},
          {13'd0, 1'b1, 1'b0, er});
      chk("hold_lin", {13'd0, out_valid_l, in_ready_l, out_overflow_l, out_data_l},
          {13'd0, 1'b1, 1'b0, el});
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", {29'd0, out_valid_r, out_valid_l, in_ready_r}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_product = '0; bias = '0;
    #12;
    chk("reset_state", {12'd0, out_valid_r, in_ready_r, out_overflow_r, out_data_r},
        {12'd0, 1'b0, 1'b1, 1'b0, 16'h0});
    @(negedge clk); rst = 1'b0;

    vec = '{32'h0001_0000}; vbias = 16'h0000;
    run_vector(0);
    chk("single_beat", {16'd0, got_l}, 32'h0100);

    vec = '{32'h0002_0000, 32'h8001_0000, 32'h0000_8000}; vbias = 16'h0080;
    run_vector(0);
    chk("three_beats", {16'd0, got_l}, 32'h0200);

    vec = '{32'h8002_0000, 32'h0001_0000}; vbias = 16'h0000;
    run_vector(1);
    chk("neg_relu", {16'd0, got_r}, 32'h0000);
    chk("neg_lin", {16'd0, got_l}, 32'h8100);

    vec = '{32'h8000_0000}; vbias = 16'h0000;
    run_vector(0);
    chk("neg_zero", {16'd0, got_l}, 32'h0000);

    vec = '{32'h3FFF_0001, 32'h3FFF_0001}; vbias = 16'h0000;
    run_vector(0);
    chk("sat_pos", {16'd0, got_l}, 32'h7FFF);

    vec = '{32'hBFFF_0001, 32'hBFFF_0001}; vbias = 16'h0000;
    run_vector(0);
    chk("sat_neg", {16'd0, got_l}, 32'hFFFF);

    vec = '{32'h0003_0000}; vbias = 16'h0000;
    run_vector(5);
    vec = '{32'h0001_0000}; vbias = 16'h0000;
    run_vector(0);
    chk("after_backpressure", {16'd0, got_l}, 32'h0100);

    @(negedge clk);
    in_valid = 1'b1; in_product = 32'h0005_0000; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_vector", {12'd0, out_valid_r, in_ready_r, out_overflow_r, out_data_r},
        {12'd0, 1'b0, 1'b1, 1'b0, 16'h0});
    @(negedge clk); rst = 1'b0;
    vec = '{32'h0001_0000}; vbias = 16'h0000;
    run_vector(0);
    chk("after_rst_mid", {16'd0, got_l}, 32'h0100);

    vec = '{32'h0004_0000}; vbias = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = (i == 0); in_product = vec[0]; in_last = 1'b1; bias = vbias;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_hold", {31'd0, out_valid_l}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_in_hold", {12'd0, out_valid_l, in_ready_l, out_overflow_l, out_data_l},
        {12'd0, 1'b0, 1'b1, 1'b0, 16'h0});
    @(negedge clk); rst = 1'b0;

    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(1, 8);
      vec.delete();
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 3))
          0: vec.push_back($urandom);
          1: vec.push_back({1'($urandom), 31'($urandom_range(0, 32'h0003_FFFF))});
          2: vec.push_back({1'($urandom), 31'h0});
          default: vec.push_back({1'($urandom), 31'($urandom_range(0, 32'h00FF_FFFF))});
        endcase
      end
      vbias = 16'($urandom);
      run_vector($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_accumulator.md
# fc_accumulator

Accumulates the stream of sign-magnitude products from the fully-connected multiply units into one neuron output. Per dot product it sums all products, adds the neuron bias, rescales to the activation fixed-point format, applies optional ReLU, saturates, and returns a DATA_WIDTH sign-magnitude activation. It sits directly downstream of the FC multiplier and feeds the activation buffer over a valid/ready handshake.

## Interface
- DATA_WIDTH, 16, activation/weight width; sign-magnitude, MSB = sign
- ACC_WIDTH, 40, two's-complement accumulator width; must be ≥ 2*DATA_WIDTH
- FRAC_BITS, 8, fractional bits of activations, weights and bias
- RELU_EN, 1, 1 = clamp negative results to zero
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  product beat valid
- in_ready  output  1  accumulator accepts a beat
- in_product  input  2*DATA_WIDTH  sign-magnitude product: [2*DW-1] sign, [2*DW-2:0] magnitude
- in_last  input  1  beat is the final term of the dot product
- bias  input  DATA_WIDTH  sign-magnitude bias, sampled with the in_last beat
- out_valid  output  1  out_data holds a finished activation
- out_ready  input  1  consumer accepts out_data
- out_data  output  DATA_WIDTH  sign-magnitude activation
- out_overflow  output  1  out_data was saturated; qualified by out_valid

## Operation
- States: ACCUM, BIAS, NORM, HOLD. Reset state ACCUM.
- ACCUM: in_ready=1. On in_valid&in_ready: acc <= acc + sm2tc(in_product). If in_last, also latch bias and go to BIAS.
- sm2tc: magnitude zero-extended to ACC_WIDTH, negated if sign=1. Negative zero (sign=1, magnitude 0) contributes 0.
- BIAS: acc <= acc + (sm2tc(bias) <<< FRAC_BITS), aligning bias to product scale (2*FRAC_BITS fractional bits). Go to NORM.
- NORM: m = |acc| >> FRAC_BITS (truncate toward zero).
  - If acc < 0 and RELU_EN: out_data=0, out_overflow=0.
  - Else if m > 2^(DW-1)-1: magnitude saturates to all ones, out_overflow=1.
  - Else magnitude=m, out_overflow=0.
  - Sign bit = (acc<0); forced 0 when magnitude is 0.
  - Register outputs, out_valid<=1, go to HOLD.
- HOLD: in_ready=0; out_data/out_overflow held stable. On out_valid&out_ready: out_valid<=0, acc<=0, go to ACCUM.
- Accumulator wraps silently on overflow. Safe vector length is ≤ 2^(ACC_WIDTH-2*DATA_WIDTH) = 256 terms at defaults. Longer vectors are out of contract.
- in_last on a single beat is legal (one-term dot product).
- in_valid while in_ready=0: ignored; upstream must hold the beat.

## Timing
- Reset values: acc=0, state=ACCUM, in_ready=1 (combinational from state), out_valid=0, out_data=0, out_overflow=0. Reset takes effect immediately and asynchronously, including mid-vector or in HOLD; partial sums are discarded.
- Throughput in ACCUM: one beat per cycle, no bubbles.
- Latency: last beat accepted at edge E0 → BIAS → NORM → out_valid=1 after edge E0+2.
- Per-vector minimum cost: N beats + 3 cycles, including the handshake cycle.
- out_valid/out_data change only on edges. No combinational path exists from out_ready to out_valid or out_data.
- The handshake edge that clears out_valid also returns in_ready to 1 for the next cycle.
- Bias is sampled only on the accepted in_last edge. Its value at other times is don't-care.

## Test plan
Defaults: DW=16, FRAC_BITS=8.
- Single beat: in_product=0x00010000 (1.0×1.0), in_last=1, bias=0x0000 → out_data=0x0100, out_overflow=0, out_valid 3 cycles after accept.
- Three beats, one per cycle: 0x00020000, 0x80010000, 0x00008000, with bias=0x0080 → 2−1+0.5+0.5 → out_data=0x0200.
- Negative sum: beats 0x80020000, 0x00010000, bias 0x0000.
  - RELU_EN=1 → out_data=0x0000.
  - RELU_EN=0 → out_data=0x8100.
  - Negative zero: beat 0x80000000 alone → out_data=0x0000.
- Saturation: two beats of 0x3FFF0001, bias 0 → out_data=0x7FFF, out_overflow=1.
  - Same beats with sign set, RELU_EN=0 → out_data=0xFFFF, out_overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0, new in_valid beats not consumed. Then out_ready=1 → next vector 0x00010000 alone yields 0x0100 (accumulator was cleared).
- Reset mid-vector: accept 0x00050000, assert rst one cycle → all outputs 0, in_ready=1. Then vector 0x00010000 with last → out_data=0x0100 (prior beat discarded).
